signed_seq_divider: RTL
=======================

Name: signed_seq_divider

Overview:
- Sequential signed integer divider; the inverse companion to the shift-add signed multiplier datapath.
- Computes Quotient = Dividend / Divisor and Remainder = Dividend mod Divisor on two's-complement operands.
- Uses restoring division on operand magnitudes, one quotient bit per clock, with sign correction at the end.
- Start/Done handshake toward the controlling FSM; sits beside the multiplier in the arithmetic unit.

Parameters:
WIDTH, 8, operand/result width in bits (two's complement); legal range 4..32.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Start  input  1  request; sampled only while Busy=0
Dividend  input  WIDTH  signed dividend, captured on accepted Start
Divisor  input  WIDTH  signed divisor, captured on accepted Start
Quotient  output  WIDTH  signed quotient, registered
Remainder  output  WIDTH  signed remainder, registered
Busy  output  1  high from the cycle after an accepted Start until the cycle Done is high (exclusive)
Done  output  1  single-cycle pulse; results valid from this cycle until the next accepted Start
Div_By_Zero  output  1  status for last operation; valid with Done
Overflow  output  1  status for last operation (most-negative / -1); valid with Done

Behaviour:
- Reset (Reset=0, async): state=IDLE; Quotient, Remainder, Busy, Done, Div_By_Zero, Overflow all 0; internal registers cleared. Reset mid-operation aborts with no Done.
- States: IDLE, CALC, FIX.
- IDLE, Start=1 at edge T0 (accept):
  - Capture operand signs and magnitudes. Magnitude width is WIDTH+1 internally, so |-2^(WIDTH-1)| is representable.
  - Clear the partial remainder; load an iteration counter = WIDTH.
  - Busy=1; clear Div_By_Zero and Overflow.
  - If Divisor==0, go to FIX directly with the zero flag set; else go to CALC.
- CALC, one edge per quotient bit, MSB first:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude. If result >= 0, keep it and set the quotient bit to 1; else restore and set it to 0.
  - Decrement counter; after exactly WIDTH edges go to FIX.
- FIX (one edge):
  - Quotient sign = sign(Dividend) XOR sign(Divisor); negate the magnitude if negative.
  - Remainder takes the sign of Dividend (truncation toward zero); zero stays zero.
  - Register Quotient/Remainder and flags; Done=1, Busy=0; go to IDLE.
- Latency, nonzero divisor: Done high in the cycle after edge T0+WIDTH+1 (WIDTH+2 edges after acceptance).
- Latency, divide-by-zero: Done high in the cycle after edge T0+1.
- Divide-by-zero result: Quotient = all ones (-1), Remainder = Dividend, Div_By_Zero=1, Overflow=0.
- Overflow: Dividend = -2^(WIDTH-1) with Divisor = -1.
  - Quotient = -2^(WIDTH-1) (wraps), Remainder = 0, Overflow=1.
- Done is a one-cycle pulse; it falls to 0 on the next edge regardless of Start.
- Start while Busy=1 is ignored; operand changes during CALC have no effect.
- Start in the same cycle Done is high is accepted (IDLE already): back-to-back operations are allowed.
- Outputs hold their last values between operations; they are not cleared at Start.

Test Plan:
- Reset=0 mid-CALC (e.g. 4 cycles after Start) -> all outputs 0 immediately (async); no Done; next Start completes normally.
- WIDTH=8, 100 / 7 -> Quotient=14, Remainder=2, flags 0; Done exactly 10 edges after the accepting edge; Busy high for the 9 preceding cycles.
- Sign combinations -> required results:
  - -100 / 7 -> Quotient=-14 (0xF2), Remainder=-2 (0xFE).
  - 100 / -7 -> Quotient=-14, Remainder=2.
  - -100 / -7 -> Quotient=14, Remainder=-2.
- -128 / -1 -> Quotient=-128 (0x80), Remainder=0, Overflow=1.
- -128 / 1 -> Quotient=-128, Remainder=0, Overflow=0.
- 5 / 0 -> Done after 2 edges; Quotient=0xFF, Remainder=5, Div_By_Zero=1.
- Start pulsed again during CALC with new operands -> ignored; first result unchanged.
- Start held high through Done -> second operation accepted in the Done cycle; its Done arrives 10 edges later.

Source files
------------

// File: rtl/signed_seq_divider.sv
// ============================================================================
// Module   : signed_seq_divider
// Purpose  : Sequential two's-complement divider. It runs restoring division
//            on the operand magnitudes at one quotient bit per clock, then
//            applies the sign correction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [WIDTH:0]     c_ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   c_ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH:0]     r_dvs_mag;
  logic [WIDTH-1:0]   r_dvd;
  logic               r_sign_dvs;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_busy;
  logic               r_done;
  logic               r_div_by_zero;
  logic               r_overflow;

  logic [WIDTH:0]     w_dvs_ext;
  logic [WIDTH:0]     w_dvs_mag;
  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH+1:0]   w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;
  logic               w_ovf;

  // Dividend magnitude fits in WIDTH unsigned bits (2^(WIDTH-1) included);
  // the divisor keeps an extra bit for the trial subtraction.
  assign w_dvs_ext = {divisor[WIDTH-1], divisor};
  assign w_dvs_mag = w_dvs_ext[WIDTH] ? (~w_dvs_ext + c_ONE) : w_dvs_ext;
  assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + c_ONE_W) : dividend;

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs_mag};
  assign w_fits  = ~w_diff[WIDTH+1];

  assign w_ovf   = ~r_dbz && (r_dvd == c_MOST_NEG) && r_sign_dvs && (r_dvs_mag == c_ONE);
  assign w_q_fix = r_dbz ? {WIDTH{1'b1}} :
                   (r_dvd[WIDTH-1] ^ r_sign_dvs) ? (~r_quo + c_ONE_W) : r_quo;
  assign w_r_fix = r_dbz ? r_dvd :
                   r_dvd[WIDTH-1] ? (~r_rem[WIDTH-1:0] + c_ONE_W) : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (divisor == '0) ? FIX : CALC;
      CALC: if (r_cnt == c_CNT_ONE) w_next = FIX;
      FIX:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs_mag     <= '0;
      r_dvd         <= '0;
      r_sign_dvs    <= 1'b0;
      r_cnt         <= '0;
      r_dbz         <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd         <= dividend;
            r_sign_dvs    <= divisor[WIDTH-1];
            r_dvs_mag     <= w_dvs_mag;
            r_quo         <= w_dvd_mag;
            r_rem         <= '0;
            r_cnt         <= c_CNT_INIT;
            r_dbz         <= (divisor == '0);
            r_busy        <= 1'b1;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_fits ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt - c_CNT_ONE;
        end
        FIX: begin
          r_quotient    <= w_q_fix;
          r_remainder   <= w_r_fix;
          r_div_by_zero <= r_dbz;
          r_overflow    <= w_ovf;
          r_busy        <= 1'b0;
          r_done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire
